ee354_button_event_decoder: RTL and testbench



---
 rtl/ee354_button_event_decoder.sv | 131 +++++++++++++
 tb/tb_ee354_button_event_decoder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ee354_button_event_decoder.sv
// Push-button event decoder: turns debouncer DPB/SCEN/MCEN strobes into
// single-cycle click, double-click, long-press and auto-repeat events.
module ee354_button_event_decoder #(
  parameter int WIN_W    = 24,
  parameter int FAST_DIV = 16
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       DPB,
  input  logic       SCEN,
  input  logic       MCEN,
  input  logic       CCEN,
  output logic       CLICK,
  output logic       DCLICK,
  output logic       LONG,
  output logic       REPEAT,
  output logic [7:0] HOLD_CNT,
  output logic       BUSY
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    HELD   = 3'd4
  } state_t;

  state_t           state;
  logic             dpb_prev;
  logic             mcen_prev;
  logic [WIN_W-1:0] win_cnt;
  logic [7:0]       div;
  logic             release_evt;
  logic             mcen_rise;

  // CCEN only reports the debouncer's internal hold timing; no event derives from it.
  logic ccen_unused;
  assign ccen_unused = CCEN;

  function automatic logic [7:0] sat_inc8(input logic [7:0] val);
    return (val == 8'hFF) ? val : val + 8'd1;
  endfunction

  assign release_evt = dpb_prev && !DPB;
  assign mcen_rise   = MCEN && !mcen_prev;
  assign BUSY        = (state != IDLE);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= IDLE;
      dpb_prev  <= 1'b0;
      mcen_prev <= 1'b0;
      win_cnt   <= '0;
      div       <= 8'd0;
      CLICK     <= 1'b0;
      DCLICK    <= 1'b0;
      LONG      <= 1'b0;
      REPEAT    <= 1'b0;
      HOLD_CNT  <= 8'd0;
    end else begin
      dpb_prev  <= DPB;
      mcen_prev <= MCEN;
      CLICK     <= 1'b0;
      DCLICK    <= 1'b0;
      LONG      <= 1'b0;
      REPEAT    <= 1'b0;

      case (state)
        IDLE: begin
          if (SCEN) begin
            state    <= PRESS1;
            HOLD_CNT <= 8'd0;
          end
        end

        PRESS1: begin
          if (MCEN) begin
            state    <= HELD;
            LONG     <= 1'b1;
            HOLD_CNT <= 8'd1;
            div      <= 8'd0;
          end else if (release_evt) begin
            state   <= WAIT2;
            win_cnt <= '0;
          end
        end

        // A second press on the very expiry cycle still counts as a double click.
        WAIT2: begin
          if (SCEN) begin
            state  <= PRESS2;
            DCLICK <= 1'b1;
          end else if (win_cnt[WIN_W-1]) begin
            state <= IDLE;
            CLICK <= 1'b1;
          end else begin
            win_cnt <= win_cnt + WIN_W'(1);
          end
        end

        PRESS2: begin
          if (release_evt) begin
            state <= IDLE;
          end
        end

        HELD: begin
          if (release_evt) begin
            state <= IDLE;
          end else if (mcen_rise) begin
            REPEAT   <= 1'b1;
            div      <= 8'd0;
            HOLD_CNT <= sat_inc8(HOLD_CNT);
          end else if (MCEN) begin
            if (div == 8'(FAST_DIV - 1)) begin
              REPEAT   <= 1'b1;
              div      <= 8'd0;
              HOLD_CNT <= sat_inc8(HOLD_CNT);
            end else begin
              div <= div + 8'd1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ee354_button_event_decoder.sv
// Directed bench for ee354_button_event_decoder with WIN_W=4 (8-cycle window)
// and FAST_DIV=4; expected values are hand-derived from the event timing.
module tb_ee354_button_event_decoder;

  logic       CLK;
  logic       RESET_N;
  logic       DPB;
  logic       SCEN;
  logic       MCEN;
  logic       CCEN;
  logic       CLICK;
  logic       DCLICK;
  logic       LONG;
  logic       REPEAT;
  logic [7:0] HOLD_CNT;
  logic       BUSY;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int n_click, n_dclick, n_long, n_repeat;
  int click_cyc, rel_cyc;

  ee354_button_event_decoder #(.WIN_W(4), .FAST_DIV(4)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .DPB     (DPB),
    .SCEN    (SCEN),
    .MCEN    (MCEN),
    .CCEN    (CCEN),
    .CLICK   (CLICK),
    .DCLICK  (DCLICK),
    .LONG    (LONG),
    .REPEAT  (REPEAT),
    .HOLD_CNT(HOLD_CNT),
    .BUSY    (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic clr();
    n_click = 0; n_dclick = 0; n_long = 0; n_repeat = 0; click_cyc = -1;
  endtask

  // One rising edge with the current inputs; outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
    if (CLICK) begin
      n_click++;
      click_cyc = cyc;
    end
    n_dclick += int'(DCLICK);
    n_long   += int'(LONG);
    n_repeat += int'(REPEAT);
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    RESET_N = 1'b0; DPB = 1'b0; SCEN = 1'b0; MCEN = 1'b0; CCEN = 1'b0;
    clr();
    tick_n(3);
    check_eq("rst_busy", BUSY, 0);
    check_eq("rst_hold", HOLD_CNT, 0);
    check_eq("rst_pulses", int'(CLICK) + int'(DCLICK) + int'(LONG) + int'(REPEAT), 0);
    RESET_N = 1'b1;
    tick_n(2);

    // Short click
    clr();
    DPB = 1'b1; SCEN = 1'b1;
    tick();
    check_eq("click_busy_press", BUSY, 1);
    SCEN = 1'b0;
    tick_n(4);
    DPB = 1'b0;
    tick();
    rel_cyc = cyc;
    tick_n(12);
    check_eq("click_count", n_click, 1);
    check_eq("click_latency", click_cyc - rel_cyc, 9);
    check_eq("click_others", n_dclick + n_long + n_repeat, 0);
    check_eq("click_busy_end", BUSY, 0);

    // Double click, SCEN three cycles after release; MCEN in PRESS2 ignored
    clr();
    DPB = 1'b1; SCEN = 1'b1;
    tick();
    SCEN = 1'b0;
    tick_n(3);
    DPB = 1'b0;
    tick();
    tick_n(2);
    DPB = 1'b1; SCEN = 1'b1;
    tick();
    check_eq("dclick_pulse", DCLICK, 1);
    SCEN = 1'b0; MCEN = 1'b1;
    tick();
    check_eq("dclick_width", DCLICK, 0);
    check_eq("dclick_press2_busy", BUSY, 1);
    MCEN = 1'b0;
    tick();
    DPB = 1'b0;
    tick();
    tick_n(12);
    check_eq("dclick_no_click", n_click, 0);
    check_eq("dclick_count", n_dclick, 1);
    check_eq("dclick_no_long", n_long + n_repeat, 0);
    check_eq("dclick_busy_end", BUSY, 0);

    // SCEN on the exact expiry cycle, then DPB glitch in PRESS2
    clr();
    DPB = 1'b1; SCEN = 1'b1;
    tick();
    SCEN = 1'b0;
    tick_n(2);
    DPB = 1'b0;
    tick();
    tick_n(8);
    DPB = 1'b1; SCEN = 1'b1;
    tick();
    check_eq("expiry_dclick", DCLICK, 1);
    check_eq("expiry_no_click", CLICK, 0);
    SCEN = 1'b0;
    tick_n(2);
    DPB = 1'b0;
    tick();
    check_eq("glitch_idle", BUSY, 0);
    DPB = 1'b1;
    tick();
    check_eq("glitch_rerise_idle", BUSY, 0);
    DPB = 1'b0;
    tick_n(12);
    check_eq("expiry_click_total", n_click, 0);
    check_eq("expiry_dclick_total", n_dclick, 1);

    // MCEN/CCEN in IDLE are ignored
    clr();
    MCEN = 1'b1; CCEN = 1'b1;
    tick_n(3);
    check_eq("idle_mcen_busy", BUSY, 0);
    check_eq("idle_mcen_pulses", n_long + n_repeat, 0);
    MCEN = 1'b0; CCEN = 1'b0;
    tick();

    // Long hold: three MCEN pulses 20 cycles apart, then 12 cycles steady high
    clr();
    DPB = 1'b1; SCEN = 1'b1;
    tick();
    SCEN = 1'b0;
    tick_n(3);
    MCEN = 1'b1;
    tick();
    check_eq("long_pulse", LONG, 1);
    check_eq("long_hold1", HOLD_CNT, 1);
    MCEN = 1'b0;
    tick_n(5);
    SCEN = 1'b1;
    tick();
    SCEN = 1'b0;
    tick_n(13);
    MCEN = 1'b1;
    tick();
    check_eq("rep_pulse2", REPEAT, 1);
    check_eq("rep_hold2", HOLD_CNT, 2);
    MCEN = 1'b0;
    tick_n(19);
    MCEN = 1'b1;
    tick();
    check_eq("rep_pulse3", REPEAT, 1);
    check_eq("rep_hold3", HOLD_CNT, 3);
    MCEN = 1'b0;
    tick_n(19);
    MCEN = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      check_eq($sformatf("steady_rep%0d", k), REPEAT, (k % 4 == 0) ? 1 : 0);
    end
    check_eq("long_hold6", HOLD_CNT, 6);
    MCEN = 1'b0; DPB = 1'b0;
    tick();
    tick_n(12);
    check_eq("long_no_click", n_click + n_dclick, 0);
    check_eq("long_count", n_long, 1);
    check_eq("long_repeats", n_repeat, 5);
    check_eq("long_hold_kept", HOLD_CNT, 6);
    check_eq("long_busy_end", BUSY, 0);

    // Saturation under continuous MCEN
    clr();
    DPB = 1'b1; SCEN = 1'b1;
    tick();
    check_eq("sat_hold_cleared", HOLD_CNT, 0);
    SCEN = 1'b0; MCEN = 1'b1;
    tick();
    check_eq("sat_long", LONG, 1);
    tick_n(1100);
    check_eq("sat_hold", HOLD_CNT, 255);
    check_eq("sat_repeats", n_repeat, 275);
    tick_n(4);
    check_eq("sat_repeat_live", REPEAT, 1);
    check_eq("sat_hold_stuck", HOLD_CNT, 255);

    // Async reset between edges while REPEAT is high
    #2;
    RESET_N = 1'b0;
    #1;
    check_eq("areset_repeat", REPEAT, 0);
    check_eq("areset_hold", HOLD_CNT, 0);
    check_eq("areset_busy", BUSY, 0);
    tick_n(2);
    RESET_N = 1'b1;
    MCEN = 1'b0; DPB = 1'b0;
    tick();
    check_eq("post_reset_idle", BUSY, 0);
    clr();
    DPB = 1'b1; SCEN = 1'b1;
    tick();
    check_eq("post_reset_press", BUSY, 1);
    SCEN = 1'b0; MCEN = 1'b1;
    tick();
    check_eq("post_reset_long", LONG, 1);
    check_eq("post_reset_norep", REPEAT, 0);
    MCEN = 1'b0; DPB = 1'b0;
    tick_n(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
